// File: rtl/i2c_pkg.sv
// Shared types for the I2C target responder.
//   i2c_op_t        : transfer direction latched from the R/W bit of the address byte.
//   i2c_slv_state_t : target FSM states.
//   I2C_ACK/I2C_NACK: SDA level of the acknowledge bit.
package i2c_pkg;

    typedef enum bit {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StAddr    = 4'd1,
        StAddrAck = 4'd2,
        StWrData  = 4'd3,
        StWrAck   = 4'd4,
        StRdWait  = 4'd5,
        StRdData  = 4'd6,
        StRdAck   = 4'd7,
        StIgnore  = 4'd8
    } i2c_slv_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer (reset to 1, the idle bus level) followed by a
// previous-value register for edge detection.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : asynchronous pin sample
//   q_o           : synchronized level
//   rise_o/fall_o : single-cycle edge strobes on the synchronized level
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign q_o    = sync2_q;
    assign rise_o = sync2_q & ~prev_q;
    assign fall_o = ~sync2_q & prev_q;

endmodule

// File: rtl/i2c_slave_resp.sv
// I2C target responder: detects START/STOP, matches a 7-bit address, ACKs,
// streams write bytes out and fetches read bytes through a req/valid
// handshake while stretching SCL.
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   scl_i, sda_i          : asynchronous bus samples
//   scl_o, sda_o          : open-drain drives (1 = release)
//   start_o, stop_o       : bus event pulses
//   busy_o, op_o          : addressed flag and latched direction
//   wr_valid_o, wr_data_o : received write byte stream
//   rd_req_o, rd_valid_i, rd_data_i : read byte handshake
module i2c_slave_resp
    import i2c_pkg::*;
#(
    parameter int unsigned                   I2C_ADDR_WIDTH = 7,
    parameter int unsigned                   I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0]     SLAVE_ADDR     = 7'h22
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      busy_o,
    output i2c_op_t                   op_o,
    output logic                      wr_valid_o,
    output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
    output logic                      rd_req_o,
    input  logic                      rd_valid_i,
    input  logic [I2C_DATA_WIDTH-1:0] rd_data_i
);

    localparam int unsigned CntW = $clog2(I2C_DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(I2C_DATA_WIDTH - 1);
    localparam logic [CntW-1:0] AllBits = CntW'(I2C_DATA_WIDTH);

    logic scl_sync, scl_rise, scl_fall;
    logic sda_sync, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .d_i    (scl_i),
        .q_o    (scl_sync),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .d_i    (sda_i),
        .q_o    (sda_sync),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    logic start_evt, stop_evt;
    assign start_evt = sda_fall & scl_sync;
    assign stop_evt  = sda_rise & scl_sync;

    i2c_slv_state_t            state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [I2C_DATA_WIDTH-1:0] sr_q, sr_d, rx_byte;
    logic                      scl_q, scl_d, sda_q, sda_d;
    logic                      start_q, start_d, stop_q, stop_d;
    logic                      busy_q, busy_d, wr_valid_q, wr_valid_d, rd_req_q, rd_req_d;
    i2c_op_t                   op_q, op_d;
    logic [I2C_DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        scl_d      = scl_q;
        sda_d      = sda_q;
        start_d    = 1'b0;
        stop_d     = 1'b0;
        busy_d     = busy_q;
        op_d       = op_q;
        wr_valid_d = 1'b0;
        wr_data_d  = wr_data_q;
        rd_req_d   = rd_req_q;
        rx_byte    = {sr_q[I2C_DATA_WIDTH-2:0], sda_sync};

        if (start_evt) begin
            state_d  = StAddr;
            cnt_d    = '0;
            start_d  = 1'b1;
            scl_d    = 1'b1;
            sda_d    = 1'b1;
            busy_d   = 1'b0;
            rd_req_d = 1'b0;
        end else if (stop_evt) begin
            state_d  = StIdle;
            stop_d   = 1'b1;
            scl_d    = 1'b1;
            sda_d    = 1'b1;
            busy_d   = 1'b0;
            rd_req_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StIgnore: ;
                StAddr: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LastBit) begin
                            cnt_d = '0;
                            if (rx_byte[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                                op_d    = i2c_op_t'(rx_byte[0]);
                                busy_d  = 1'b1;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                // Entered with SDA released: the first SCL fall starts the ACK
                // drive, the second one ends it.
                StAddrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (sda_q) begin
                            sda_d = I2C_ACK;
                        end else begin
                            sda_d = 1'b1;
                            cnt_d = '0;
                            if (state_q == StWrAck || op_q == I2C_WRITE) begin
                                state_d = StWrData;
                            end else begin
                                state_d  = StRdWait;
                                rd_req_d = 1'b1;
                                scl_d    = 1'b0;
                            end
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LastBit) begin
                            cnt_d      = '0;
                            wr_data_d  = rx_byte;
                            wr_valid_d = 1'b1;
                            state_d    = StWrAck;
                        end
                    end
                end
                StRdWait: begin
                    if (rd_req_q && rd_valid_i) begin
                        sr_d     = rd_data_i;
                        sda_d    = rd_data_i[I2C_DATA_WIDTH-1];
                        scl_d    = 1'b1;
                        rd_req_d = 1'b0;
                        cnt_d    = CntW'(1);
                        state_d  = StRdData;
                    end
                end
                // cnt_q counts bits already placed on SDA; MSB went out on load.
                StRdData: begin
                    if (scl_fall) begin
                        if (cnt_q == AllBits) begin
                            sda_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = StRdAck;
                        end else begin
                            sda_d = sr_q[I2C_DATA_WIDTH-2];
                            sr_d  = sr_q << 1;
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                // cnt_q = 1 marks a sampled ACK; the following fall starts the next byte.
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_sync == I2C_NACK) state_d = StIgnore;
                        else                      cnt_d   = CntW'(1);
                    end else if (scl_fall && cnt_q == CntW'(1)) begin
                        cnt_d    = '0;
                        state_d  = StRdWait;
                        rd_req_d = 1'b1;
                        scl_d    = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            sr_q       <= '0;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            op_q       <= I2C_WRITE;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            scl_q      <= scl_d;
            sda_q      <= sda_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            op_q       <= op_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
        end
    end

    assign scl_o      = scl_q;
    assign sda_o      = sda_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;
    assign op_o       = op_q;
    assign wr_valid_o = wr_valid_q;
    assign wr_data_o  = wr_data_q;
    assign rd_req_o   = rd_req_q;

endmodule

// File: tb/tb_i2c_slave_resp.sv
// Bench for i2c_slave_resp: a bit-level I2C master drives a wired-AND bus,
// a responder feeds read bytes, and expectations come from the protocol rules.
module tb_i2c_slave_resp;
    import i2c_pkg::*;

    localparam logic [6:0] SlaveAddr = 7'h22;
    localparam int         Budget    = 2000;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_o, sda_o, start_o, stop_o, busy_o, wr_valid_o, rd_req_o;
    i2c_op_t    op_o;
    logic [7:0] wr_data_o;
    logic       rd_valid_i;
    logic [7:0] rd_data_i;
    logic       scl_line, sda_line;

    assign scl_line = scl_m & scl_o;
    assign sda_line = sda_m & sda_o;

    always #5 clk_i = ~clk_i;

    i2c_slave_resp dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_line),
        .sda_i      (sda_line),
        .scl_o      (scl_o),
        .sda_o      (sda_o),
        .start_o    (start_o),
        .stop_o     (stop_o),
        .busy_o     (busy_o),
        .op_o       (op_o),
        .wr_valid_o (wr_valid_o),
        .wr_data_o  (wr_data_o),
        .rd_req_o   (rd_req_o),
        .rd_valid_i (rd_valid_i),
        .rd_data_i  (rd_data_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor: event counters, captured write stream, SCL stretch lengths.
    int         start_cnt = 0, stop_cnt = 0, rdreq_cnt = 0, busy_cycles = 0;
    int         low_run = 0, last_low_run = 0;
    logic       rd_req_prev = 1'b0;
    logic [7:0] wr_seen[$];

    initial begin
        forever begin
            @(negedge clk_i);
            if (start_o) start_cnt++;
            if (stop_o) stop_cnt++;
            if (wr_valid_o) wr_seen.push_back(wr_data_o);
            if (rd_req_o && !rd_req_prev) rdreq_cnt++;
            rd_req_prev = rd_req_o;
            if (busy_o) busy_cycles++;
            if (!scl_o) low_run++;
            else if (low_run != 0) begin
                last_low_run = low_run;
                low_run = 0;
            end
        end
    end

    // Read-data responder: answers rd_req_o after rd_delay cycles.
    logic [7:0] rd_bytes[256];
    int         rd_idx = 0;
    int         rd_delay = 0;

    initial begin
        rd_valid_i = 1'b0;
        rd_data_i  = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rd_req_o) begin
                repeat (rd_delay) @(negedge clk_i);
                rd_data_i  = rd_bytes[rd_idx % 256];
                rd_idx++;
                rd_valid_i = 1'b1;
                @(negedge clk_i);
                rd_valid_i = 1'b0;
            end
        end
    end

    function automatic logic exp_addr_ack(input logic [7:0] a);
        return (a[7:1] == SlaveAddr) ? I2C_ACK : I2C_NACK;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_scl_high();
        int waited = 0;
        while (scl_line !== 1'b1 && waited < Budget) begin
            @(negedge clk_i);
            waited++;
        end
        if (scl_line !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL scl_release: scl line %b, required 1 within %0d cycles", scl_line, Budget);
        end
    endtask

    task automatic m_bit(input logic b, output logic r);
        sda_m = b;
        wait_clks(5);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(5);
        r = sda_line;
        wait_clks(5);
        scl_m = 1'b0;
        wait_clks(5);
    endtask

    task automatic m_start();
        sda_m = 1'b1;
        wait_clks(5);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(10);
        sda_m = 1'b0;
        wait_clks(10);
        scl_m = 1'b0;
        wait_clks(5);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        wait_clks(5);
        scl_m = 1'b1;
        wait_scl_high();
        wait_clks(10);
        sda_m = 1'b1;
        wait_clks(10);
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read_byte(input logic ack_bit, output logic [7:0] d);
        logic r;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, r);
            d = {d[6:0], r};
        end
        m_bit(ack_bit, r);
    endtask

    // Full write transaction; a NACKed address ends with STOP.
    task automatic xfer_write(input logic [7:0] addr, input logic [7:0] data[$], input string tag);
        int   w0 = wr_seen.size();
        int   b0 = busy_cycles;
        int   p0 = stop_cnt;
        logic ack;
        logic exp_ack = exp_addr_ack(addr);
        m_start();
        m_write_byte(addr, ack);
        n_tests++;
        if (ack !== exp_ack) begin
            n_fail++;
            $display("FAIL %s addr_ack: got %b, required %b (addr %h)", tag, ack, exp_ack, addr);
        end
        if (exp_ack == I2C_ACK) begin
            n_tests++;
            if (op_o !== I2C_WRITE || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL %s op_busy: got op %0d busy %b, required op 0 busy 1", tag, op_o, busy_o);
            end
            foreach (data[k]) begin
                m_write_byte(data[k], ack);
                n_tests++;
                if (ack !== I2C_ACK) begin
                    n_fail++;
                    $display("FAIL %s data_ack[%0d]: got %b, required 0", tag, k, ack);
                end
            end
        end
        m_stop();
        n_tests++;
        if (exp_ack == I2C_ACK) begin
            if (wr_seen.size() - w0 != data.size()) begin
                n_fail++;
                $display("FAIL %s wr_count: got %0d, required %0d", tag, wr_seen.size() - w0, data.size());
            end else begin
                foreach (data[k]) begin
                    if (wr_seen[w0 + k] !== data[k]) begin
                        n_fail++;
                        $display("FAIL %s wr_data[%0d]: got %h, required %h", tag, k, wr_seen[w0 + k], data[k]);
                        break;
                    end
                end
            end
        end else if (wr_seen.size() != w0 || busy_cycles != b0) begin
            n_fail++;
            $display("FAIL %s ignored: got %0d writes %0d busy cycles, required 0 and 0",
                     tag, wr_seen.size() - w0, busy_cycles - b0);
        end
        n_tests++;
        if (stop_cnt - p0 != 1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stop: got %0d stop pulses busy %b, required 1 and 0", tag, stop_cnt - p0, busy_o);
        end
    endtask

    // Read transaction: master ACKs all bytes but the last, then clocks one more
    // byte to confirm the target has gone quiet, then STOP.
    task automatic xfer_read(input logic [7:0] data[$], input int delay, input string tag);
        int         r0 = rdreq_cnt;
        int         p0 = stop_cnt;
        logic       ack;
        logic [7:0] got;
        foreach (data[k]) rd_bytes[(rd_idx + k) % 256] = data[k];
        rd_delay = delay;
        m_start();
        m_write_byte({SlaveAddr, 1'b1}, ack);
        n_tests++;
        if (ack !== I2C_ACK || op_o !== I2C_READ) begin
            n_fail++;
            $display("FAIL %s addr: got ack %b op %0d, required ack 0 op 1", tag, ack, op_o);
        end
        foreach (data[k]) begin
            m_read_byte((k == data.size() - 1) ? I2C_NACK : I2C_ACK, got);
            n_tests++;
            if (got !== data[k]) begin
                n_fail++;
                $display("FAIL %s rd_data[%0d]: got %h, required %h", tag, k, got, data[k]);
            end
        end
        if (delay >= 20) begin
            n_tests++;
            if (last_low_run < delay) begin
                n_fail++;
                $display("FAIL %s stretch: got %0d cycles, required >= %0d", tag, last_low_run, delay);
            end
        end
        m_write_byte(8'hFF, ack);
        n_tests++;
        if (ack !== I2C_NACK || rdreq_cnt - r0 != data.size()) begin
            n_fail++;
            $display("FAIL %s ignore_req: got ack %b rd_req %0d, required ack 1 rd_req %0d",
                     tag, ack, rdreq_cnt - r0, data.size());
        end
        m_stop();
        n_tests++;
        if (stop_cnt - p0 != 1 || busy_o !== 1'b0 || rd_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stop: got %0d stops busy %b rd_req %b, required 1 0 0",
                     tag, stop_cnt - p0, busy_o, rd_req_o);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_tests++;
        if ({scl_o, sda_o, start_o, stop_o, busy_o, wr_valid_o, rd_req_o} !== 7'b1100000 ||
            op_o !== I2C_WRITE || wr_data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: got scl %b sda %b start %b stop %b busy %b wv %b req %b op %0d wd %h, required 1 1 0 0 0 0 0 0 00",
                     tag, scl_o, sda_o, start_o, stop_o, busy_o, wr_valid_o, rd_req_o, op_o, wr_data_o);
        end
    endtask

    task automatic test_reset();
        wait_clks(3);
        check_reset_outputs("reset_values");
        rst_i = 1'b1;
        wait_clks(10);
        n_tests++;
        if (start_cnt != 0 || stop_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_no_events: got %0d starts %0d stops, required 0 0", start_cnt, stop_cnt);
        end
    endtask

    task automatic test_write();
        int          s0 = start_cnt;
        logic [7:0]  d[$];
        d.push_back(8'h78);
        xfer_write(8'h44, d, "write");
        n_tests++;
        if (start_cnt - s0 != 1) begin
            n_fail++;
            $display("FAIL write start: got %0d start pulses, required 1", start_cnt - s0);
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] d[$];
        logic [7:0] a;
        d.push_back(8'h5A);
        xfer_write(8'h46, d, "mismatch_46");
        for (int i = 0; i < 3; i++) begin
            do a = 8'($urandom); while (a[7:1] == SlaveAddr);
            xfer_write(a, d, "mismatch_rand");
        end
    endtask

    task automatic test_random_writes();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d[$];
            int n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) d.push_back(8'($urandom));
            xfer_write({SlaveAddr, 1'b0}, d, "rand_write");
        end
    endtask

    task automatic test_read();
        logic [7:0] d[$];
        d.push_back(8'hA5);
        xfer_read(d, 20, "read");
    endtask

    task automatic test_read_burst();
        logic [7:0] d[$];
        d = '{8'h01, 8'h02, 8'h03};
        xfer_read(d, 0, "burst_fixed");
        d = '{8'($urandom), 8'($urandom), 8'($urandom)};
        xfer_read(d, $urandom_range(1, 6), "burst_rand");
    endtask

    task automatic test_back_to_back();
        int         s0 = start_cnt;
        logic       ack;
        logic [7:0] got;
        rd_bytes[rd_idx % 256] = 8'h3C;
        rd_delay = 2;
        m_start();
        m_write_byte({SlaveAddr, 1'b0}, ack);
        m_write_byte(8'h10, ack);
        m_start();
        m_write_byte({SlaveAddr, 1'b1}, ack);
        n_tests++;
        if (start_cnt - s0 != 2 || op_o !== I2C_READ || ack !== I2C_ACK) begin
            n_fail++;
            $display("FAIL rstart: got %0d starts op %0d ack %b, required 2 starts op 1 ack 0",
                     start_cnt - s0, op_o, ack);
        end
        m_read_byte(I2C_NACK, got);
        n_tests++;
        if (got !== 8'h3C || wr_seen[$] !== 8'h10) begin
            n_fail++;
            $display("FAIL rstart_data: got rd %h wr %h, required rd 3c wr 10", got, wr_seen[$]);
        end
        m_stop();
    endtask

    task automatic test_reset_mid();
        logic       r;
        logic [7:0] d[$];
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(8'h44 >> i, r);
        n_tests++;
        if (sda_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ack_drive: got sda_o %b, required 0", sda_o);
        end
        rst_i = 1'b0;
        #1;
        n_tests++;
        if (sda_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_async: got sda_o %b, required 1", sda_o);
        end
        wait_clks(3);
        check_reset_outputs("midreset_values");
        rst_i = 1'b1;
        wait_clks(3);
        m_bit(1'b1, r);
        m_stop();
        d = '{8'($urandom), 8'($urandom)};
        xfer_write(8'h44, d, "post_reset_write");
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_read_burst();
        test_back_to_back();
        test_random_writes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
